bullet_unit: RTL

Per-tank projectile engine for the tank battle game. On a fire request it launches one bullet from the owning tank's position and facing, advances it one pixel per movement tick across the 160x120 arena, and retires it on an arena-edge exit or an external hit. It sits upstream of `draw`, supplying the bullet position, enable and direction inputs. It also supplies the `bNready` flag consumed by `control`. One instance per tank.

---
 rtl/bullet_unit_if.sv | 25 ++
 rtl/bullet_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bullet_unit_if.sv
// Port bundle between one tank's control and its bullet engine.
// The master drives fire/hit/tank pose; the bullet_unit (slave) returns the bullet state.
interface bullet_unit_if;
    logic       fire;
    logic       hit;
    logic [7:0] tank_x;
    logic [6:0] tank_y;
    logic [1:0] tank_d;
    logic [7:0] bx;
    logic [6:0] by;
    logic [1:0] bdir;
    logic       active;
    logic       ready;
    logic       step;

    modport master (
        output fire, hit, tank_x, tank_y, tank_d,
        input  bx, by, bdir, active, ready, step
    );

    modport slave (
        input  fire, hit, tank_x, tank_y, tank_d,
        output bx, by, bdir, active, ready, step
    );
endinterface

// File: rtl/bullet_unit.sv
// Per-tank projectile engine: launches on a fire edge, moves one pixel per tick,
// retires on arena exit or hit, then enforces a cooldown before the next shot.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | no bullet, ready=1, waiting for a fire edge
// S_FLIGHT   | bullet moving, active=1
// S_COOLDOWN | bullet retired, counting COOLDOWN_TICKS ticks
module bullet_unit #(
    parameter int TICK_DIV       = 833333,
    parameter int COOLDOWN_TICKS = 30,
    parameter int X_MIN          = 21,
    parameter int X_MAX          = 137,
    parameter int Y_MIN          = 1,
    parameter int Y_MAX          = 117
) (
    input  logic         clk,
    input  logic         resetn,
    bullet_unit_if.slave bus
);
    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CDW     = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam int CD_LAST = (COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0;
    localparam int CW      = 10;

    localparam logic signed [CW-1:0] X_LO = CW'(X_MIN);
    localparam logic signed [CW-1:0] X_HI = CW'(X_MAX);
    localparam logic signed [CW-1:0] Y_LO = CW'(Y_MIN);
    localparam logic signed [CW-1:0] Y_HI = CW'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLIGHT   = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      bx_q;
    logic [6:0]      by_q;
    logic [1:0]      bdir_q;
    logic            active_q;
    logic            ready_q;
    logic            step_q;
    logic [TW-1:0]   tick_cnt;
    logic [CDW-1:0]  cool_cnt;
    logic            fire_q;
    logic            armed;

    logic                 tick;
    logic                 fire_edge;
    logic                 cool_done;
    logic signed [CW-1:0] spawn_x, spawn_y;
    logic signed [CW-1:0] next_x, next_y;
    logic                 spawn_ok, next_ok;

    // armed stays low for the first clock after reset so a held fire only loads history
    assign fire_edge = armed & ~fire_q & bus.fire;
    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign cool_done = (COOLDOWN_TICKS == 0) || (tick && (cool_cnt == CDW'(CD_LAST)));

    always_comb begin
        spawn_x = $signed({2'b00, bus.tank_x});
        spawn_y = $signed({3'b000, bus.tank_y});
        case (bus.tank_d)
            2'd0: begin spawn_x = spawn_x + 10'sd4; spawn_y = spawn_y - 10'sd1; end
            2'd1: begin spawn_x = spawn_x + 10'sd9; spawn_y = spawn_y + 10'sd4; end
            2'd2: begin spawn_x = spawn_x + 10'sd4; spawn_y = spawn_y + 10'sd9; end
            default: begin spawn_x = spawn_x - 10'sd1; spawn_y = spawn_y + 10'sd4; end
        endcase
    end

    always_comb begin
        next_x = $signed({2'b00, bx_q});
        next_y = $signed({3'b000, by_q});
        case (bdir_q)
            2'd0: next_y = next_y - 10'sd1;
            2'd1: next_x = next_x + 10'sd1;
            2'd2: next_y = next_y + 10'sd1;
            default: next_x = next_x - 10'sd1;
        endcase
    end

    assign spawn_ok = (spawn_x >= X_LO) && (spawn_x <= X_HI) &&
                      (spawn_y >= Y_LO) && (spawn_y <= Y_HI);
    assign next_ok  = (next_x >= X_LO) && (next_x <= X_HI) &&
                      (next_y >= Y_LO) && (next_y <= Y_HI);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            bx_q     <= '0;
            by_q     <= '0;
            bdir_q   <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            step_q   <= 1'b0;
            tick_cnt <= '0;
            cool_cnt <= '0;
            fire_q   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed  <= 1'b1;
            fire_q <= bus.fire;
            step_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire_edge && spawn_ok) begin
                        bx_q     <= spawn_x[7:0];
                        by_q     <= spawn_y[6:0];
                        bdir_q   <= bus.tank_d;
                        tick_cnt <= '0;
                        active_q <= 1'b1;
                        ready_q  <= 1'b0;
                        state    <= S_FLIGHT;
                    end
                end
                S_FLIGHT: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    // hit wins over a coincident tick; the cooldown timer restarts from zero
                    if (bus.hit || (tick && !next_ok)) begin
                        active_q <= 1'b0;
                        step_q   <= 1'b1;
                        tick_cnt <= '0;
                        cool_cnt <= '0;
                        state    <= S_COOLDOWN;
                    end else if (tick) begin
                        bx_q   <= next_x[7:0];
                        by_q   <= next_y[6:0];
                        step_q <= 1'b1;
                    end
                end
                S_COOLDOWN: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick) cool_cnt <= cool_cnt + 1'b1;
                    if (cool_done) begin
                        tick_cnt <= '0;
                        ready_q  <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    ready_q  <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.bx     = bx_q;
    assign bus.by     = by_q;
    assign bus.bdir   = bdir_q;
    assign bus.active = active_q;
    assign bus.ready  = ready_q;
    assign bus.step   = step_q;
endmodule
